// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types and constants for the byte-substitution blocks.
package aes_pkg;

    localparam int AES_STATE_BYTES = 16;

    typedef logic [7:0]                     aes_byte_t;
    typedef logic [8*AES_STATE_BYTES-1:0]   aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } aes_fsm_t;

endpackage

// File: rtl/inv_sbox_unit.sv
// inv_sbox_unit: combinational AES inverse S-box, full 256-entry table.
module inv_sbox_unit
    import aes_pkg::*;
(
    input  aes_byte_t i_byte,
    output aes_byte_t o_byte
);

    // Entry 0 occupies the most significant byte of the table.
    localparam logic [2047:0] INV_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // (255 - i_byte) * 8 selects entry i_byte from the top.
    assign o_byte = INV_TABLE[{~i_byte, 3'b000} +: 8];

endmodule

// File: rtl/sbox_unit.sv
// sbox_unit: combinational AES forward S-box, full 256-entry table.
// Compiled only with INV_SUB_BYTES_FWD_CHECK_EN, its sole user here.
`ifdef INV_SUB_BYTES_FWD_CHECK_EN
module sbox_unit
    import aes_pkg::*;
(
    input  aes_byte_t i_byte,
    output aes_byte_t o_byte
);

    localparam logic [2047:0] FWD_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = FWD_TABLE[{~i_byte, 3'b000} +: 8];

endmodule
`endif

// File: rtl/inv_sub_bytes.sv
// inv_sub_bytes: iterative AES InvSubBytes, LANES bytes per cycle.
// Optional INV_SUB_BYTES_FWD_CHECK_EN adds a forward S-box round-trip
// check with sticky check_err output.
module inv_sub_bytes
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_state_t in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t out_data
`ifdef INV_SUB_BYTES_FWD_CHECK_EN
    ,
    output logic       check_err
`endif
);

    localparam int            CHUNKS = AES_STATE_BYTES / LANES;
    localparam int            CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST   = CW'(CHUNKS - 1);

    aes_fsm_t      r_fsm;
    logic [CW-1:0] r_cnt;
    aes_state_t    r_state;
    logic          r_in_ready;
    logic          r_out_valid;

    aes_byte_t     w_bytes      [AES_STATE_BYTES];
    aes_byte_t     w_next_bytes [AES_STATE_BYTES];
    aes_byte_t     w_lane_in    [LANES];
    aes_byte_t     w_lane_out   [LANES];
    logic [3:0]    w_lane_idx   [LANES];
    aes_state_t    w_next_state;

    // Unpack the working state and pick the bytes of the current chunk.
    always_comb begin
        for (int unsigned b = 0; b < AES_STATE_BYTES; b++) begin
            w_bytes[b] = r_state[127 - 8*b -: 8];
        end
        for (int unsigned l = 0; l < LANES; l++) begin
            w_lane_idx[l] = 4'(32'(r_cnt) * 32'(LANES) + l);
            w_lane_in[l]  = w_bytes[w_lane_idx[l]];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_sbox_unit u_inv (
            .i_byte (w_lane_in[g]),
            .o_byte (w_lane_out[g])
        );
    end

    // Merge substituted lane bytes back into the state.
    always_comb begin
        w_next_bytes = w_bytes;
        w_next_state = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_next_bytes[w_lane_idx[l]] = w_lane_out[l];
        end
        for (int unsigned b = 0; b < AES_STATE_BYTES; b++) begin
            w_next_state[127 - 8*b -: 8] = w_next_bytes[b];
        end
    end

    // Control FSM: accept, process one chunk per edge, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_cnt       <= '0;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= in_data;
                        r_cnt      <= '0;
                        r_fsm      <= PROC;
                        r_in_ready <= 1'b0;
                    end
                end
                PROC: begin
                    r_state <= w_next_state;
                    if (r_cnt == LAST) begin
                        r_cnt       <= '0;
                        r_fsm       <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_fsm       <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_state;

`ifdef INV_SUB_BYTES_FWD_CHECK_EN
    aes_byte_t w_fwd [LANES];
    logic      w_mismatch;
    logic      r_check_err;

    for (genvar g = 0; g < LANES; g++) begin : g_chk
        sbox_unit u_fwd (
            .i_byte (w_lane_out[g]),
            .o_byte (w_fwd[g])
        );
    end

    // Any lane whose forward image differs from its input is an error.
    always_comb begin
        w_mismatch = 1'b0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (w_fwd[l] != w_lane_in[l]) w_mismatch = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_check_err <= 1'b0;
        end else if (r_fsm == PROC && w_mismatch) begin
            r_check_err <= 1'b1;
        end
    end

    assign check_err = r_check_err;
`endif

endmodule

// File: tb/tb_inv_sub_bytes.sv
// tb_inv_sub_bytes: scoreboard bench for inv_sub_bytes with LANES=4 and
// LANES=1 instances; expected values come from a GF(2^8) reference model.
module tb_inv_sub_bytes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_s       [2];
    logic         in_valid_s  [2];
    logic         in_ready_s  [2];
    logic [127:0] in_data_s   [2];
    logic         out_valid_s [2];
    logic         out_ready_s [2];
    logic [127:0] out_data_s  [2];
`ifdef INV_SUB_BYTES_FWD_CHECK_EN
    logic         check_err_s [2];
`endif

    inv_sub_bytes #(.LANES(4)) dut4 (
        .clk       (clk),
        .rst       (rst_s[0]),
        .in_valid  (in_valid_s[0]),
        .in_ready  (in_ready_s[0]),
        .in_data   (in_data_s[0]),
        .out_valid (out_valid_s[0]),
        .out_ready (out_ready_s[0]),
        .out_data  (out_data_s[0])
`ifdef INV_SUB_BYTES_FWD_CHECK_EN
        ,
        .check_err (check_err_s[0])
`endif
    );

    inv_sub_bytes #(.LANES(1)) dut1 (
        .clk       (clk),
        .rst       (rst_s[1]),
        .in_valid  (in_valid_s[1]),
        .in_ready  (in_ready_s[1]),
        .in_data   (in_data_s[1]),
        .out_valid (out_valid_s[1]),
        .out_ready (out_ready_s[1]),
        .out_data  (out_data_s[1])
`ifdef INV_SUB_BYTES_FWD_CHECK_EN
        ,
        .check_err (check_err_s[1])
`endif
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [127:0] q0 [$];
    logic [127:0] q1 [$];
    logic [7:0]   inv_tbl [256];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] v = 8'h00;
        logic [7:0] r;
        logic [7:0] s;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
            end
        end
        s = v ^ 8'h63;
        r = v;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st);
        logic [127:0] o = '0;
        for (int b = 0; b < 16; b++) begin
            o[127 - 8*b -: 8] = inv_tbl[st[127 - 8*b -: 8]];
        end
        return o;
    endfunction

    task automatic run_op(input int d, input logic [127:0] data, input logic [127:0] exp,
                          input int lat, input int stall, input bit noisy);
        int n;
        int e;
        bit seen;
        logic [127:0] held;
        logic [127:0] want;
        n = 0;
        while (!in_ready_s[d] && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("ready", 128'(in_ready_s[d]), 128'(1'b1));
        in_valid_s[d] = 1'b1;
        in_data_s[d]  = data;
        @(posedge clk);
        if (d == 0) q0.push_back(exp); else q1.push_back(exp);
        #1;
        in_valid_s[d] = noisy;
        seen = 1'b0;
        e = 0;
        while (!seen && e < 64) begin
            if (noisy) in_data_s[d] = {$urandom, $urandom, $urandom, $urandom};
            chk("busy_rdy", 128'(in_ready_s[d]), 128'(1'b0));
            @(posedge clk);
            #1;
            e++;
            seen = out_valid_s[d];
        end
        chk("latency", 128'(e), 128'(lat));
        want = '0;
        if (d == 0 && q0.size() > 0) want = q0.pop_front();
        if (d == 1 && q1.size() > 0) want = q1.pop_front();
        chk("data", out_data_s[d], want);
        held = out_data_s[d];
        for (int s = 0; s < stall; s++) begin
            if (noisy) in_data_s[d] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            chk("stall_vld", 128'(out_valid_s[d]), 128'(1'b1));
            chk("stall_dat", out_data_s[d], held);
            chk("stall_rdy", 128'(in_ready_s[d]), 128'(1'b0));
        end
        in_valid_s[d]  = 1'b0;
        out_ready_s[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s[d] = 1'b0;
        chk("exit_vld", 128'(out_valid_s[d]), 128'(1'b0));
        chk("exit_rdy", 128'(in_ready_s[d]), 128'(1'b1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] data;
        for (int i = 0; i < 256; i++) inv_tbl[fwd_sbox(8'(i))] = 8'(i);

        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1;
            in_valid_s[d] = 1'b0;
            in_data_s[d] = '0;
            out_ready_s[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_data", out_data_s[d], '0);
            chk("rst_vld", 128'(out_valid_s[d]), 128'(1'b0));
            chk("rst_rdy", 128'(in_ready_s[d]), 128'(1'b1));
`ifdef INV_SUB_BYTES_FWD_CHECK_EN
            chk("rst_err", 128'(check_err_s[d]), 128'(1'b0));
`endif
        end

        // Known vector with a 3-cycle output stall.
        run_op(0, 128'h637C777BF26B6FC53001672BFED7AB76,
               128'h000102030405060708090A0B0C0D0E0F, 4, 3, 1'b0);

        // Single-lane instance: 16 edges of latency.
        run_op(1, {16{8'h16}}, {16{8'hFF}}, 16, 0, 1'b0);
        run_op(1, {16{8'h00}}, {16{8'h52}}, 16, 1, 1'b0);

        // Abort mid-PROC with reset after two chunks.
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = 128'h0123456789ABCDEFFEDCBA9876543210;
        @(posedge clk);
        #1;
        in_valid_s[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_s[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_s[0] = 1'b0;
        chk("abort_vld", 128'(out_valid_s[0]), 128'(1'b0));
        chk("abort_data", out_data_s[0], '0);
        chk("abort_rdy", 128'(in_ready_s[0]), 128'(1'b1));
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            chk("abort_idle", 128'(out_valid_s[0]), 128'(1'b0));
        end
        run_op(0, 128'h0123456789ABCDEFFEDCBA9876543210,
               model(128'h0123456789ABCDEFFEDCBA9876543210), 4, 0, 1'b0);

        // in_valid held with changing in_data while busy.
        data = 128'hDEADBEEFCAFEF00D0011223344556677;
        run_op(0, data, model(data), 4, 2, 1'b1);
        data = 128'h8899AABBCCDDEEFF1020304050607080;
        run_op(1, data, model(data), 16, 2, 1'b1);

        // Sweep every byte value through the four-lane instance.
        for (int k = 0; k < 16; k++) begin
            for (int b = 0; b < 16; b++) data[127 - 8*b -: 8] = 8'(16*k + b);
            run_op(0, data, model(data), 4, 0, 1'b0);
`ifdef INV_SUB_BYTES_FWD_CHECK_EN
            chk("check_err", 128'(check_err_s[0]), 128'(1'b0));
`endif
        end

        // A few random states on both instances.
        for (int r = 0; r < 4; r++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            run_op(r % 2, data, model(data), (r % 2 == 0) ? 4 : 16, r, 1'b0);
        end

`ifdef INV_SUB_BYTES_FWD_CHECK_EN
        chk("check_err1", 128'(check_err_s[1]), 128'(1'b0));
`endif
        chk("sb_empty", 128'(q0.size() + q1.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
